adder_seq_ctrl: RTL and testbench

//  Sequencer that runs a WIDTH-bit add/subtract through one shared SLICE-bit

---
 rtl/adder_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_adder_seq_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract built from one shared SLICE-bit carry-select slice.
// The slice works on one SLICE-bit chunk per clock, LSB first, and a register carries the carry between slices.
module adder_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    generate
        if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_width
            $error("adder_seq_ctrl: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Both ready and valid come straight from registers, with no combinational
    // path between the two sides. The producer holds valid and data stable until
    // the transfer.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry;
    logic [IDXW-1:0]   idx;

    logic [SLICE-1:0]  a_sl;
    logic [SLICE-1:0]  b_sl;
    logic [SLICE:0]    res0;
    logic [SLICE:0]    res1;
    logic [SLICE-1:0]  slice_sum;
    logic              slice_c;

    assign dbg_state = state;

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDXW'(i)) begin
                a_sl = a_q[i*SLICE +: SLICE];
                b_sl = b_q[i*SLICE +: SLICE];
            end
        end
    end

    // Both carry-in outcomes are computed; the registered carry picks one.
    assign res0 = {1'b0, a_sl} + {1'b0, b_sl};
    assign res1 = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(1);
    assign {slice_c, slice_sum} = carry ? res1 : res0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= op ? ~b : b;
                        carry    <= op ? 1'b1 : cin;
                        idx      <= '0;
                        sum      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (idx == IDXW'(i)) sum[i*SLICE +: SLICE] <= slice_sum;
                    end
                    carry <= slice_c;
                    if (idx == LAST_IDX) begin
                        cout      <= slice_c;
                        ovf       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                     (slice_sum[SLICE-1] != a_q[WIDTH-1]);
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed and random checks of adder_seq_ctrl (WIDTH=32, SLICE=8) against a full-width arithmetic model.
module tb_adder_seq_ctrl;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;

    adder_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic [WIDTH-1:0] observed, input logic [WIDTH-1:0] expected,
                         input string tag);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
        end
    endtask

    // Reference model: the whole operation done at once in WIDTH+1-bit arithmetic.
    task automatic model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic tcin, input logic top,
                         output logic [WIDTH-1:0] es, output logic ec, output logic eo);
        logic [WIDTH-1:0] beff;
        logic [WIDTH:0]   full;
        beff = top ? ~tb_v : tb_v;
        full = {1'b0, ta} + {1'b0, beff} + {{WIDTH{1'b0}}, (top ? 1'b1 : tcin)};
        es = full[WIDTH-1:0];
        ec = full[WIDTH];
        eo = (ta[WIDTH-1] == beff[WIDTH-1]) && (full[WIDTH-1] != ta[WIDTH-1]);
    endtask

    // Accept one op, scramble inputs during RUN, wait for the result and check it.
    // The caller decides whether to release the result immediately.
    task automatic issue_and_wait(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                                  input logic tcin, input logic top, input string tag);
        logic [WIDTH-1:0] es;
        logic             ec, eo;
        int               lat;
        model(ta, tb_v, tcin, top, es, ec, eo);
        check(WIDTH'(in_ready), WIDTH'(1), {tag, "_pre_in_ready"});
        a = ta; b = tb_v; cin = tcin; op = top; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); op = 1'($urandom);
        check(WIDTH'(in_ready), WIDTH'(0), {tag, "_run_in_ready"});
        lat = 0;
        while (lat < 3 * NSLICE) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        check(WIDTH'(lat), WIDTH'(NSLICE), {tag, "_latency"});
        check(sum, es, {tag, "_sum"});
        check(WIDTH'(cout), WIDTH'(ec), {tag, "_cout"});
        check(WIDTH'(ovf), WIDTH'(eo), {tag, "_ovf"});
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check(WIDTH'(out_valid), WIDTH'(0), {tag, "_post_out_valid"});
        check(WIDTH'(in_ready), WIDTH'(1), {tag, "_post_in_ready"});
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic tcin, input logic top, input string tag);
        issue_and_wait(ta, tb_v, tcin, top, tag);
        release_result(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] held_sum;
        logic [WIDTH-1:0] es;
        logic             ec, eo;
        bit               seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; op = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check(WIDTH'(in_ready), WIDTH'(1), "rst_in_ready");
        check(WIDTH'(out_valid), WIDTH'(0), "rst_out_valid");
        check(sum, '0, "rst_sum");
        check(WIDTH'(cout), WIDTH'(0), "rst_cout");
        check(WIDTH'(ovf), WIDTH'(0), "rst_ovf");

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "add_ff_1");
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "ripple");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "pos_ovf");
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, "sub_5_7");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, "sub_neg_ovf");

        // The last result must be kept through idle cycles.
        model(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, es, ec, eo);
        repeat (3) @(posedge clk);
        #1;
        check(sum, es, "idle_retain_sum");
        check(WIDTH'(cout), WIDTH'(ec), "idle_retain_cout");

        // Backpressure: a new request in DONE must not be taken.
        issue_and_wait(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, "bp");
        held_sum = sum;
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; cin = 1'b0; op = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check(WIDTH'(out_valid), WIDTH'(1), "bp_out_valid");
            check(sum, held_sum, "bp_sum_stable");
            check(WIDTH'(in_ready), WIDTH'(0), "bp_in_ready");
        end
        in_valid = 1'b0;
        release_result("bp");
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1, "bp_next");

        // Reset in the middle of RUN, after two slices have been processed.
        a = 32'hCAFE_0001; b = 32'h0000_FFFF; cin = 1'b1; op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check(WIDTH'(in_ready), WIDTH'(1), "midrst_in_ready");
        check(sum, '0, "midrst_sum");
        seen = 1'b0;
        for (int i = 0; i < 2 * NSLICE; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check(WIDTH'(seen), WIDTH'(0), "midrst_no_out_valid");
        run_op(32'h0F0F_0F0F, 32'h00F0_F0F1, 1'b1, 1'b0, "midrst_next");

        // Random operations against the model.
        for (int i = 0; i < 25; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = {1'b0, {(WIDTH-1){1'b1}}};
            run_op(ra, rb, 1'($urandom), 1'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
